// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable generator with graceful stop and
// glitch-free runtime divisor updates through a one-slot shadow.
module tick_scheduler #(
    parameter int          CNT_W       = 32,
    parameter int          NUM_CH      = 4,
    parameter int unsigned DEFAULT_DIV = 24_999_999
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    stop,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                        cfg_div,
    input  logic                                    cfg_en,
    output logic                                    busy,
    output logic [NUM_CH-1:0]                       tick,
    output logic [NUM_CH-1:0]                       tog
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  div [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] en;

    logic [CH_W-1:0]   sh_ch;
    logic [CNT_W-1:0]  sh_div;
    logic              sh_en;
    logic              pending;

    logic [NUM_CH-1:0] run_ch;
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] tog_nxt;
    logic [NUM_CH-1:0] apply;
    logic              go_idle;
    logic              acc;
    logic              ch_ok;

    assign pending = ~cfg_ready;
    assign acc     = cfg_valid & cfg_ready;
    assign ch_ok   = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);

    always_comb begin
        run_ch  = '0;
        term    = '0;
        tog_nxt = '0;
        apply   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_ch[i] = en[i] && ((state == RUN) ||
                        ((state == STOPPING) && tog[i]));
            term[i]   = run_ch[i] && (cnt[i] == div[i]);
            if (term[i])
                tog_nxt[i] = (pending && (sh_ch == CH_W'(i)) && !sh_en)
                             ? 1'b0 : ~tog[i];
            else if (run_ch[i])
                tog_nxt[i] = tog[i];
        end
        // Leave STOPPING on the very edge the last square wave falls.
        go_idle = (state == STOPPING) && (tog_nxt == '0);
        for (int i = 0; i < NUM_CH; i++)
            apply[i] = pending && (sh_ch == CH_W'(i)) && (term[i] || go_idle);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)   state_nxt = RUN;
            RUN:      if (stop)    state_nxt = STOPPING;
            STOPPING: if (go_idle) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            sh_ch     <= '0;
            sh_div    <= '0;
            sh_en     <= 1'b0;
            en        <= '0;
            tick      <= '0;
            tog       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div[i] <= CNT_W'(DEFAULT_DIV);
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            tog   <= tog_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!run_ch[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                end else if (term[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b1;
                end else begin
                    cnt[i]  <= cnt[i] + 1'b1;
                    tick[i] <= 1'b0;
                end
            end
            // Accept and apply are exclusive: accept needs the slot empty.
            if (acc && ch_ok) begin
                if ((state == IDLE) || !en[cfg_ch]) begin
                    div[cfg_ch] <= cfg_div;
                    en[cfg_ch]  <= cfg_en;
                end else begin
                    sh_ch     <= cfg_ch;
                    sh_div    <= cfg_div;
                    sh_en     <= cfg_en;
                    cfg_ready <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply[i]) begin
                    div[i]    <= sh_div;
                    en[i]     <= sh_en;
                    cfg_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: reset, divide, runtime update,
// graceful stop, enable/disable and handshake contention.
module tb_tick_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        busy;
    logic [3:0]  tick;
    logic [3:0]  tog;

    int n_vec;
    int n_err;
    int k;

    tick_scheduler #(
        .CNT_W      (16),
        .NUM_CH     (4),
        .DEFAULT_DIV(7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .busy     (busy),
        .tick     (tick),
        .tog      (tog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic cfg_set(input logic [1:0] ch, input logic [15:0] d,
                           input logic e);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_en    = e;
    endtask

    task automatic cfg_idle_write(input logic [1:0] ch, input logic [15:0] d,
                                  input logic e);
        cfg_set(ch, d, e);
        step();
        cfg_valid = 1'b0;
        chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_tog", 32'(tog), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        k = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
        cfg_en = 1'b0;
        #12;
        do_reset();

        // basic divide: ch0 div=3, ch1 div=0
        cfg_idle_write(2'd0, 16'd3, 1'b1);
        cfg_idle_write(2'd1, 16'd0, 1'b1);
        do_start();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_e0_tick", 32'(tick), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("b_tick0", 32'(tick[0]), 32'((k % 4) == 0));
            chk("b_tog0", 32'(tog[0]), 32'((k / 4) & 1));
            chk("b_tick1", 32'(tick[1]), 32'd1);
            chk("b_tog1", 32'(tog[1]), 32'(k & 1));
        end

        // runtime update ch0 div 3 -> 1
        step();
        cfg_set(2'd0, 16'd1, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("upd_ready14", 32'(cfg_ready), 32'd0);
        step();
        chk("upd_ready15", 32'(cfg_ready), 32'd0);
        chk("upd_tick15", 32'(tick[0]), 32'd0);
        step();
        chk("upd_tick16", 32'(tick[0]), 32'd1);
        chk("upd_ready16", 32'(cfg_ready), 32'd1);
        for (int i = 17; i <= 22; i++) begin
            step();
            chk("u_tick0", 32'(tick[0]), 32'((k % 2) == 0));
            chk("u_tog0", 32'(tog[0]), 32'(((k - 16) / 2) & 1));
        end

        // async reset with a pending update outstanding
        cfg_set(2'd0, 16'd5, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("pre_rst_ready", 32'(cfg_ready), 32'd0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();

        // graceful stop: ch0 div=3, ch1 div=9
        cfg_idle_write(2'd0, 16'd3, 1'b1);
        cfg_idle_write(2'd1, 16'd9, 1'b1);
        do_start();
        for (int i = 1; i <= 12; i++) step();
        chk("gs_tog1_hi", 32'(tog[1]), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b1;
        for (int i = 13; i <= 21; i++) begin
            if (i > 13) step();
            chk("gs_busy", 32'(busy), 32'(k < 20));
            chk("gs_tick0", 32'(tick[0]), 32'(k == 16));
            chk("gs_tog0", 32'(tog[0]), 32'(k < 16));
            chk("gs_tick1", 32'(tick[1]), 32'(k == 20));
            chk("gs_tog1", 32'(tog[1]), 32'(k < 20));
            if (k >= 16) start = 1'b0;
        end

        // enable/disable on ch0
        cfg_idle_write(2'd1, 16'd9, 1'b0);
        do_start();
        for (int i = 1; i <= 8; i++) step();
        chk("ed_tog0_lo", 32'(tog[0]), 32'd0);
        cfg_set(2'd0, 16'd3, 1'b0);
        step();
        cfg_valid = 1'b0;
        for (int i = 9; i <= 11; i++) begin
            if (i > 9) step();
            chk("ed_ready", 32'(cfg_ready), 32'd0);
            chk("ed_tick0", 32'(tick[0]), 32'd0);
        end
        step();
        chk("ed_tick12", 32'(tick[0]), 32'd1);
        chk("ed_tog12", 32'(tog[0]), 32'd0);
        chk("ed_ready12", 32'(cfg_ready), 32'd1);
        for (int i = 13; i <= 18; i++) begin
            step();
            chk("ed_off_tick", 32'(tick[0]), 32'd0);
            chk("ed_off_tog", 32'(tog[0]), 32'd0);
        end
        cfg_set(2'd0, 16'd2, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("re_ready", 32'(cfg_ready), 32'd1);
        step();
        chk("re_tick20", 32'(tick[0]), 32'd0);
        step();
        chk("re_tick21", 32'(tick[0]), 32'd0);
        step();
        chk("re_tick22", 32'(tick[0]), 32'd1);
        chk("re_tog22", 32'(tog[0]), 32'd1);
        chk("re_busy", 32'(busy), 32'd1);

        // back-to-back config writes
        cfg_set(2'd0, 16'd2, 1'b1);
        step();
        chk("bb_ready23", 32'(cfg_ready), 32'd0);
        cfg_set(2'd0, 16'd4, 1'b1);
        step();
        chk("bb_ready24", 32'(cfg_ready), 32'd0);
        step();
        chk("bb_tick25", 32'(tick[0]), 32'd1);
        chk("bb_ready25", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        chk("bb_ready26", 32'(cfg_ready), 32'd0);
        step();
        chk("bb_tick27", 32'(tick[0]), 32'd0);
        step();
        chk("bb_tick28", 32'(tick[0]), 32'd1);
        chk("bb_ready28", 32'(cfg_ready), 32'd1);
        for (int i = 29; i <= 33; i++) begin
            step();
            chk("bb_tick_d4", 32'(tick[0]), 32'(k == 33));
        end

        // start&stop together: RUN -> STOPPING, IDLE -> RUN
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 60 && busy; i++) step();
        chk("stop_wins_run", 32'(busy), 32'd0);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_idle_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("start_wins_idle", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
